// File: rtl/recip_freq_counter.sv
// Reciprocal frequency / period / duty counter for an asynchronous sig_clk_i, measured over
// whole signal periods spanning at least a programmable gate, all in the ref_clk_i domain.
module recip_freq_counter #(
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned GATE_WIDTH     = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic                  ref_clk_i,
    input  logic                  ref_rst_n_i,
    input  logic                  sig_clk_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  cfg_cont_i,
    input  logic [GATE_WIDTH-1:0] cfg_gate_time_i,
    output logic                  busy_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [CNT_WIDTH-1:0]  res_sig_cnt_o,
    output logic [CNT_WIDTH-1:0]  res_ref_cnt_o,
    output logic [CNT_WIDTH-1:0]  res_high_cnt_o,
    output logic                  res_ovf_o,
    output logic                  res_timeout_o
);

    localparam int unsigned TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {StIdle, StArm, StGate, StClose, StDone} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;
    logic                   sig_s;
    logic                   sig_p;

    logic [CNT_WIDTH-1:0]   ref_q, sig_q, high_q;
    logic [CNT_WIDTH-1:0]   ref_inc, sig_inc, high_inc;
    logic [GATE_WIDTH-1:0]  gate_q, gate_inc, gate_time_q;
    logic [TO_WIDTH-1:0]    idle_q, idle_inc;
    logic                   ovf_q, ovf_inc;
    logic                   cont_q;
    logic                   gate_hit, idle_hit;

    logic                   busy_q, res_valid_q, res_ovf_q, res_timeout_q;
    logic [CNT_WIDTH-1:0]   res_sig_q, res_ref_q, res_high_q;

    // Synchroniser chain plus one extra flop for rising-edge detection
    always_ff @(posedge ref_clk_i or negedge ref_rst_n_i) begin
        if (!ref_rst_n_i) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_clk_i};
            sig_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign sig_p = sig_s & ~sig_d_q;

    // Saturating next values; any result counter pinned at all-ones raises the sticky ovf
    always_comb begin
        ref_inc  = ref_q;
        sig_inc  = sig_q;
        high_inc = high_q;
        gate_inc = gate_q;
        ovf_inc  = ovf_q;
        if (&ref_q) begin
            ovf_inc = 1'b1;
        end else begin
            ref_inc = ref_q + CNT_WIDTH'(1);
        end
        if (sig_p) begin
            if (&sig_q) begin
                ovf_inc = 1'b1;
            end else begin
                sig_inc = sig_q + CNT_WIDTH'(1);
            end
        end
        if (sig_s) begin
            if (&high_q) begin
                ovf_inc = 1'b1;
            end else begin
                high_inc = high_q + CNT_WIDTH'(1);
            end
        end
        if (!(&gate_q)) begin
            gate_inc = gate_q + GATE_WIDTH'(1);
        end
    end

    assign gate_hit = (gate_inc >= gate_time_q);
    assign idle_inc = idle_q + TO_WIDTH'(1);
    assign idle_hit = (idle_inc >= TO_LIMIT);

    always_ff @(posedge ref_clk_i or negedge ref_rst_n_i) begin
        if (!ref_rst_n_i) begin
            state_q       <= StIdle;
            ref_q         <= '0;
            sig_q         <= '0;
            high_q        <= '0;
            gate_q        <= '0;
            gate_time_q   <= '0;
            idle_q        <= '0;
            ovf_q         <= 1'b0;
            cont_q        <= 1'b0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_sig_q     <= '0;
            res_ref_q     <= '0;
            res_high_q    <= '0;
            res_ovf_q     <= 1'b0;
            res_timeout_q <= 1'b0;
        end else if (abort_i) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        gate_time_q <= (cfg_gate_time_i == '0) ? GATE_WIDTH'(1) : cfg_gate_time_i;
                        cont_q      <= cfg_cont_i;
                        ref_q       <= '0;
                        sig_q       <= '0;
                        high_q      <= '0;
                        gate_q      <= '0;
                        idle_q      <= '0;
                        ovf_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StArm;
                    end
                end
                StArm: begin
                    if (sig_p) begin
                        ref_q   <= '0;
                        sig_q   <= '0;
                        high_q  <= '0;
                        gate_q  <= '0;
                        idle_q  <= '0;
                        state_q <= StGate;
                    end else if (idle_hit) begin
                        res_sig_q     <= sig_q;
                        res_ref_q     <= ref_q;
                        res_high_q    <= high_q;
                        res_ovf_q     <= ovf_q;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= StDone;
                    end else begin
                        idle_q <= idle_inc;
                    end
                end
                StGate, StClose: begin
                    ref_q  <= ref_inc;
                    sig_q  <= sig_inc;
                    high_q <= high_inc;
                    gate_q <= gate_inc;
                    ovf_q  <= ovf_inc;
                    idle_q <= sig_p ? '0 : idle_inc;
                    // A closing edge is counted into the result it closes
                    if (sig_p && (state_q == StClose || gate_hit)) begin
                        res_sig_q     <= sig_inc;
                        res_ref_q     <= ref_inc;
                        res_high_q    <= high_inc;
                        res_ovf_q     <= ovf_inc;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= StDone;
                    end else if (!sig_p && idle_hit) begin
                        res_sig_q     <= sig_q;
                        res_ref_q     <= ref_q;
                        res_high_q    <= high_q;
                        res_ovf_q     <= ovf_q;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= StDone;
                    end else if (state_q == StGate && gate_hit) begin
                        state_q <= StClose;
                    end
                end
                StDone: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        if (cont_q) begin
                            ref_q   <= '0;
                            sig_q   <= '0;
                            high_q  <= '0;
                            gate_q  <= '0;
                            idle_q  <= '0;
                            ovf_q   <= 1'b0;
                            state_q <= StArm;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign res_valid_o    = res_valid_q;
    assign res_sig_cnt_o  = res_sig_q;
    assign res_ref_cnt_o  = res_ref_q;
    assign res_high_cnt_o = res_high_q;
    assign res_ovf_o      = res_ovf_q;
    assign res_timeout_o  = res_timeout_q;

endmodule

// File: tb/tb_recip_freq_counter.sv
// Directed bench for recip_freq_counter: small counters and a short timeout so saturation
// and timeout are reachable; sig_clk_i is generated in lock-step with ref_clk_i.
module tb_recip_freq_counter;

    localparam int unsigned CW = 8;
    localparam int unsigned GW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig_clk = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cont = 1'b0;
    logic [GW-1:0] gate_time = '0;
    logic          ready = 1'b0;
    logic          busy, valid, ovf, tmo;
    logic [CW-1:0] sig_cnt, ref_cnt, high_cnt;

    int n_checks = 0;
    int n_fail = 0;

    int sig_period = 0;
    int sig_high = 0;
    int sig_ph = 0;

    recip_freq_counter #(
        .CNT_WIDTH     (CW),
        .GATE_WIDTH    (GW),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .ref_clk_i      (clk),
        .ref_rst_n_i    (rst_n),
        .sig_clk_i      (sig_clk),
        .start_i        (start),
        .abort_i        (abort),
        .cfg_cont_i     (cont),
        .cfg_gate_time_i(gate_time),
        .busy_o         (busy),
        .res_valid_o    (valid),
        .res_ready_i    (ready),
        .res_sig_cnt_o  (sig_cnt),
        .res_ref_cnt_o  (ref_cnt),
        .res_high_cnt_o (high_cnt),
        .res_ovf_o      (ovf),
        .res_timeout_o  (tmo)
    );

    always #5 clk = ~clk;

    // Periodic signal: sig_high cycles high out of every sig_period ref cycles
    always @(negedge clk) begin
        if (sig_period == 0) begin
            sig_clk = 1'b0;
        end else begin
            sig_ph  = (sig_ph + 1) % sig_period;
            sig_clk = (sig_ph < sig_high);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic set_wave(input int p, input int h);
        sig_period = p;
        sig_high   = h;
        repeat (3 * p + 8) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({busy, valid, ovf, tmo} !== 4'b0 || sig_cnt !== '0 || ref_cnt !== '0 || high_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b valid=%b ovf=%b tmo=%b sig=%0d ref=%0d high=%0d, expected all 0",
                     busy, valid, ovf, tmo, sig_cnt, ref_cnt, high_cnt);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b valid=%b, expected 0 0", busy, valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        set_wave(10, 5);
        gate_time = 16'd100;
        ready = 1'b0;
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, expected 1", busy);
        end
        wait_valid(400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_valid: got no result, expected one within 400 cycles");
        end
        n_checks++;
        if (sig_cnt !== 8'd10 || ref_cnt !== 8'd100 || high_cnt !== 8'd50) begin
            n_fail++;
            $display("FAIL basic_counts: got sig=%0d ref=%0d high=%0d, expected 10 100 50", sig_cnt, ref_cnt, high_cnt);
        end
        n_checks++;
        if (ovf !== 1'b0 || tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: got ovf=%b tmo=%b, expected 0 0", ovf, tmo);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: got valid=%b busy=%b, expected 0 0", valid, busy);
        end
    endtask

    task automatic test_gate_midperiod();
        bit ok;
        set_wave(7, 3);
        gate_time = 16'd20;
        pulse_start();
        gate_time = 16'd5;
        wait_valid(400, ok);
        n_checks++;
        if (!ok || sig_cnt !== 8'd3 || ref_cnt !== 8'd21 || high_cnt !== 8'd9) begin
            n_fail++;
            $display("FAIL midperiod_counts: got valid=%b sig=%0d ref=%0d high=%0d, expected 1 3 21 9",
                     ok, sig_cnt, ref_cnt, high_cnt);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_coincident();
        bit ok;
        set_wave(5, 2);
        gate_time = 16'd10;
        pulse_start();
        wait_valid(400, ok);
        n_checks++;
        if (!ok || sig_cnt !== 8'd2 || ref_cnt !== 8'd10 || high_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL coincident_counts: got valid=%b sig=%0d ref=%0d high=%0d, expected 1 2 10 4",
                     ok, sig_cnt, ref_cnt, high_cnt);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        set_wave(0, 0);
        gate_time = 16'd10;
        pulse_start();
        n = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 64) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles in ARM, expected 64", n);
        end
        n_checks++;
        if (tmo !== 1'b1 || ovf !== 1'b0 || sig_cnt !== '0 || ref_cnt !== '0 || high_cnt !== '0) begin
            n_fail++;
            $display("FAIL timeout_result: got tmo=%b ovf=%b sig=%0d ref=%0d high=%0d, expected 1 0 0 0 0",
                     tmo, ovf, sig_cnt, ref_cnt, high_cnt);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_saturation_hold();
        bit ok;
        set_wave(4, 2);
        gate_time = 16'd1000;
        pulse_start();
        wait_valid(1200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sat_valid: got no result, expected one within 1200 cycles");
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (valid !== 1'b1 || ref_cnt !== 8'd255 || sig_cnt !== 8'd250 || high_cnt !== 8'd255 ||
                ovf !== 1'b1 || tmo !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_hold[%0d]: got valid=%b sig=%0d ref=%0d high=%0d ovf=%b tmo=%b, expected 1 250 255 255 1 0",
                         i, valid, sig_cnt, ref_cnt, high_cnt, ovf, tmo);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_accept: got valid=%b, expected 0", valid);
        end
    endtask

    task automatic test_abort_start();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_with_start: got busy=%b, expected 0", busy);
        end
        set_wave(6, 3);
        gate_time = 16'd20;
        pulse_start();
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: got busy=%b valid=%b, expected 0 0", busy, valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int results;
        int n;
        bit saw;
        set_wave(6, 3);
        gate_time = 16'd20;
        cont = 1'b1;
        ready = 1'b1;
        pulse_start();
        results = 0;
        n = 0;
        while (results < 3 && n < 600) begin
            if (valid) begin
                results++;
                n_checks++;
                if (sig_cnt !== 8'd4 || ref_cnt !== 8'd24 || high_cnt !== 8'd12 ||
                    int'(ref_cnt) != int'(sig_cnt) * 6 || ovf !== 1'b0 || tmo !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cont_result[%0d]: got sig=%0d ref=%0d high=%0d ovf=%b tmo=%b, expected 4 24 12 0 0",
                             results, sig_cnt, ref_cnt, high_cnt, ovf, tmo);
                end
            end
            tick();
            n++;
        end
        n_checks++;
        if (results != 3) begin
            n_fail++;
            $display("FAIL cont_count: got %0d results, expected 3", results);
        end
        repeat (10) tick();
        n_checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_in_gate: got busy=%b valid=%b, expected 1 0", busy, valid);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cont = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_abort: got busy=%b valid=%b, expected 0 0", busy, valid);
        end
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (valid || busy) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (saw) begin
            n_fail++;
            $display("FAIL cont_after_abort: got activity after abort, expected none");
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gate_midperiod();
        test_coincident();
        test_timeout();
        test_saturation_hold();
        test_abort_start();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
